// File: rtl/i2c_read_sequencer.sv
// i2c_read_sequencer: issues a burst of 16-bit register reads to an I2C master and queues the results in a FWFT FIFO.
module i2c_read_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  chip_addr,
  input  logic [7:0]  base_reg,
  input  logic [7:0]  count,
  output logic        cmd_ready,
  output logic [6:0]  m_chip_addr,
  output logic [7:0]  m_reg_addr,
  output logic        m_read_en,
  input  logic        m_busy,
  input  logic [3:0]  m_status,
  input  logic [15:0] m_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        seq_done,
  output logic        seq_error,
  output logic [7:0]  reads_left
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, PUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] chip_q, chip_d;
  logic [7:0] reg_q, reg_d, left_q, left_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic err_q, err_d;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [15:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] occ_q, occ_d;
  logic full, pop, push;
  assign full = occ_q == (AW+1)'(FIFO_DEPTH);
  assign pop  = rd_valid && rd_ready;
  // a full FIFO still accepts the word when the consumer pops in the same cycle
  assign push = state_q == PUSH && (!full || pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      chip_q  <= '0;
      reg_q   <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      chip_q  <= chip_d;
      reg_q   <= reg_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb begin
    state_d = state_q;
    chip_d  = chip_q;
    reg_d   = reg_q;
    left_d  = left_q;
    cnt_d   = '0;
    word_d  = word_q;
    err_d   = err_q;
    mem_d   = mem_q;
    if (push) mem_d[wp_q] = word_q;
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      IDLE: if (start) begin
        chip_d  = chip_addr;
        reg_d   = base_reg;
        left_d  = count;
        err_d   = 1'b0;
        state_d = (count == 8'd0) ? DONE : ISSUE;
      end
      ISSUE: state_d = HOLD;
      HOLD: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q + 32'd1 >= 32'(HOLDOFF)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (!m_busy) begin
          word_d  = m_data;
          err_d   = err_q | (m_status != 4'd0);
          state_d = (m_status == 4'd0) ? PUSH : DONE;
        end else if (cnt_q >= 32'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      PUSH: if (push) begin
        left_d  = left_q - 8'd1;
        reg_d   = reg_q + 8'd1;
        state_d = (left_q == 8'd1) ? DONE : ISSUE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready   = state_q == IDLE;
    m_read_en   = state_q == ISSUE;
    seq_done    = state_q == DONE;
    m_chip_addr = chip_q;
    m_reg_addr  = reg_q;
    rd_valid    = occ_q != '0;
    rd_data     = mem_q[rp_q];
    seq_error   = err_q;
    reads_left  = left_q;
  end
endmodule

// File: tb/tb_i2c_read_sequencer.sv
// tb_i2c_read_sequencer: randomized bursts against a queue-based model of reads issued and words delivered.
module tb_i2c_read_sequencer;
  localparam int DEPTH = 4, HOLDOFF = 2, TMO = 24;
  logic clk = 0, reset = 1, start = 0, rd_ready = 0;
  logic [6:0] chip_addr = 0;
  logic [7:0] base_reg = 0, count = 0;
  logic m_busy = 0;
  logic [3:0] m_status = 0;
  logic [15:0] m_data = 0;
  logic cmd_ready, m_read_en, rd_valid, seq_done, seq_error;
  logic [6:0] m_chip_addr;
  logic [7:0] m_reg_addr, reads_left;
  logic [15:0] rd_data;
  i2c_read_sequencer #(.FIFO_DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .chip_addr(chip_addr), .base_reg(base_reg),
    .count(count), .cmd_ready(cmd_ready), .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr),
    .m_read_en(m_read_en), .m_busy(m_busy), .m_status(m_status), .m_data(m_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .seq_done(seq_done),
    .seq_error(seq_error), .reads_left(reads_left)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [15:0] regmem [256];
  int rr_mode = 1, force_l = 0, hang_pct = 0, done_cnt = 0, pushes = 0;
  logic [7:0] exp_reads[$];
  logic [15:0] exp_words[$];
  logic [7:0] issued[$];
  logic [15:0] popped[$];
  logic [6:0] exp_chip = 0;
  logic [7:0] exp_base = 0, exp_cnt = 0;
  logic exp_err = 0;
  int t = 0, lat = 0;
  logic s_act = 0, hang = 0, fin_ok = 0;
  logic [15:0] fin_data = 0;
  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  // slave model: busy rises two cycles after the request, status/data only valid once busy drops
  always @(negedge clk) begin
    if (reset) s_act = 0;
    else if (m_read_en) begin
      issued.push_back(m_reg_addr);
      chk("read_en_expected", 32'(exp_reads.size() > 0), 1);
      if (exp_reads.size() > 0) chk("m_reg_addr", m_reg_addr, exp_reads.pop_front());
      chk("m_chip_addr", m_chip_addr, exp_chip);
      s_act = 1;
      t = 0;
      lat = force_l != 0 ? force_l : $urandom_range(2, 8);
      hang = $urandom_range(0, 99) < hang_pct;
      if (hang) lat = 1000;
      fin_ok = (m_chip_addr == 7'h0F) && !hang;
      fin_data = regmem[m_reg_addr];
      if (fin_ok) begin
        exp_words.push_back(fin_data);
        pushes++;
      end else begin
        exp_err = 1;
        exp_reads.delete();
      end
    end else if (s_act) t++;
    m_busy = s_act && t >= 2 && t < 2 + lat;
    m_status = !s_act ? 4'h0 : (t < 2 + lat) ? 4'h8 : (fin_ok ? 4'h0 : 4'h3);
    m_data = (s_act && t >= 2 + lat) ? fin_data : 16'hDEAD;
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) begin
        chk("rd_valid_expected", 32'(exp_words.size() > 0), 1);
        if (exp_words.size() > 0) chk("rd_data", rd_data, exp_words[0]);
      end
      if (seq_done) begin
        done_cnt++;
        chk("done_pending_reads", exp_reads.size(), 0);
        chk("seq_error", seq_error, exp_err);
        chk("reads_left", reads_left, 32'(exp_cnt) - 32'(pushes));
        chk("m_reg_addr_end", m_reg_addr, 8'(32'(exp_base) + pushes));
      end
      rd_ready = rr_mode == 2 ? 1'($urandom_range(0, 1)) : rr_mode != 0;
      if (rd_valid && rd_ready && exp_words.size() > 0) popped.push_back(exp_words.pop_front());
    end
  end
  task automatic burst(input logic [6:0] c, input logic [7:0] b, input logic [7:0] n);
    int k = 0;
    while (!cmd_ready && k < 3000) begin tick(); k++; end
    chk("cmd_ready_before_start", cmd_ready, 1);
    exp_chip = c; exp_base = b; exp_cnt = n; exp_err = 0; pushes = 0;
    exp_reads.delete(); issued.delete(); popped.delete();
    for (int i = 0; i < n; i++) exp_reads.push_back(8'(b + i));
    start = 1; chip_addr = c; base_reg = b; count = n;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin tick(); k++; end
    chk("seq_done_seen", 32'(done_cnt != d0), 1);
    chk("idle_after_done", {seq_done, cmd_ready}, 2'b01);
    tick();
    chk("seq_done_once", done_cnt, d0 + 1);
  endtask
  task automatic drain;
    int k = 0;
    rr_mode = 1;
    while (exp_words.size() > 0 && k < 500) begin tick(); k++; end
    tick();
    chk("drained_rd_valid", rd_valid, 0);
  endtask
  task automatic check_reset_vals;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_read_en", m_read_en, 0);
    chk("rst_chip", m_chip_addr, 0);
    chk("rst_reg", m_reg_addr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_seq_error", seq_error, 0);
    chk("rst_reads_left", reads_left, 0);
  endtask
  initial begin
    int d0, k;
    logic [6:0] c;
    for (int i = 0; i < 256; i++) regmem[i] = {8'(i), ~8'(i)} ^ 16'h5A5A;
    regmem[0] = 16'hA1A1;
    regmem[1] = 16'hB2B2;
    repeat (3) tick();
    check_reset_vals();
    reset = 0;
    // two reads from a live slave
    d0 = done_cnt;
    burst(7'h0F, 8'h00, 8'd2);
    wait_done(d0);
    chk("t1_reads", issued.size(), 2);
    chk("t1_reg0", issued[0], 8'h00);
    chk("t1_reg1", issued[1], 8'h01);
    drain();
    chk("t1_words", popped.size(), 2);
    chk("t1_word0", popped[0], 16'hA1A1);
    chk("t1_word1", popped[1], 16'hB2B2);
    // empty burst
    d0 = done_cnt;
    burst(7'h0F, 8'h33, 8'd0);
    chk("t2_done_next_cycle", seq_done, 1);
    tick();
    chk("t2_done_low", seq_done, 0);
    chk("t2_no_reads", issued.size(), 0);
    chk("t2_rd_valid", rd_valid, 0);
    chk("t2_done_count", done_cnt, d0 + 1);
    // FIFO back-pressure
    rr_mode = 0;
    d0 = done_cnt;
    burst(7'h0F, 8'h10, 8'd6);
    repeat (120) tick();
    chk("t3_stall_reads", issued.size(), 5);
    chk("t3_stall_valid", rd_valid, 1);
    chk("t3_stall_busy", cmd_ready, 0);
    chk("t3_no_done", done_cnt, d0);
    rr_mode = 1;
    wait_done(d0);
    drain();
    chk("t3_words", popped.size(), 6);
    chk("t3_word0", popped[0], 16'h4AB5);
    chk("t3_word5", popped[5], 16'h4FB0);
    // register address wrap
    d0 = done_cnt;
    burst(7'h0F, 8'hFF, 8'd2);
    wait_done(d0);
    chk("t4_reg0", issued[0], 8'hFF);
    chk("t4_reg1", issued[1], 8'h00);
    drain();
    // absent slave, then error cleared by the next start
    d0 = done_cnt;
    burst(7'h10, 8'h05, 8'd3);
    wait_done(d0);
    chk("t5_error", seq_error, 1);
    chk("t5_reads", issued.size(), 1);
    drain();
    d0 = done_cnt;
    burst(7'h0F, 8'h05, 8'd1);
    chk("t5_error_cleared", seq_error, 0);
    wait_done(d0);
    drain();
    // master never drops busy
    hang_pct = 100;
    d0 = done_cnt;
    burst(7'h0F, 8'h20, 8'd2);
    wait_done(d0);
    chk("t6_timeout_error", seq_error, 1);
    chk("t6_reads", issued.size(), 1);
    hang_pct = 0;
    drain();
    // reset in the middle of a burst
    force_l = 30;
    d0 = done_cnt;
    burst(7'h0F, 8'h40, 8'd3);
    k = 0;
    while (issued.size() == 0 && k < 200) begin tick(); k++; end
    chk("t7_first_read", issued.size(), 1);
    repeat (5) tick();
    reset = 1;
    exp_reads.delete(); exp_words.delete(); issued.delete();
    tick();
    check_reset_vals();
    reset = 0;
    repeat (20) tick();
    chk("t7_no_reads_after_reset", issued.size(), 0);
    chk("t7_no_done", done_cnt, d0);
    force_l = 0;
    d0 = done_cnt;
    burst(7'h0F, 8'h41, 8'd2);
    wait_done(d0);
    chk("t7_restart_reads", issued.size(), 2);
    drain();
    // randomized bursts, with stray starts while busy
    repeat (40) begin
      c = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(16, 127)) : 7'h0F;
      hang_pct = ($urandom_range(0, 3) == 0) ? 15 : 0;
      rr_mode = $urandom_range(1, 2);
      d0 = done_cnt;
      burst(c, 8'($urandom), 8'($urandom_range(0, 9)));
      tick();
      if (!cmd_ready) begin
        start = 1; chip_addr = 7'($urandom); base_reg = 8'($urandom); count = 8'($urandom);
        tick();
        start = 0;
      end
      wait_done(d0);
      drain();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
